// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
//   Shared definitions for the two-channel status LED controller:
//   - mode_t       : base mode encoding driven from PS GPIO
//   - chan_state_t : per-channel sequencer states
//   - DEF_*        : default timing constants (Hz / ms)
//   - base_level() : LED level produced by a base mode and the blink phases
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_ON   = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_FAST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_BASE,
        ST_FLASH_ON,
        ST_FLASH_OFF,
        ST_GAP
    } chan_state_t;

    localparam int unsigned DEF_CLK_HZ   = 25_000_000;
    localparam int unsigned DEF_FLASH_MS = 100;
    localparam int unsigned DEF_GAP_MS   = 400;
    localparam int unsigned DEF_SLOW_MS  = 500;
    localparam int unsigned DEF_FAST_MS  = 125;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic base_level(input mode_t mode, input logic slow_phase,
                                        input logic fast_phase);
        case (mode)
            MODE_OFF:  return 1'b0;
            MODE_ON:   return 1'b1;
            MODE_SLOW: return slow_phase;
            default:   return fast_phase;
        endcase
    endfunction

endpackage

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
//   One LED sequencer. In BASE the LED follows the base mode; an accepted
//   event with a non-zero count plays N on/off flashes followed by a dark
//   gap, then returns to BASE. All timing is counted in ms ticks.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   ms_tick      : one-cycle pulse per millisecond
//   mode         : base mode (off / on / slow / fast)
//   slow_phase   : slow blink phase as it will be after this edge
//   fast_phase   : fast blink phase as it will be after this edge
//   evt_valid    : event request
//   evt_count    : number of flashes requested (0 = no-op)
//   evt_ready    : high exactly while in BASE (registered)
//   led          : LED drive, 1 = lit (registered)
// -----------------------------------------------------------------------------
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_MS = DEF_FLASH_MS,
    parameter int unsigned GAP_MS   = DEF_GAP_MS,
    parameter int unsigned TMR_W    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ms_tick,
    input  mode_t      mode,
    input  logic       slow_phase,
    input  logic       fast_phase,
    input  logic       evt_valid,
    input  logic [3:0] evt_count,
    output logic       evt_ready,
    output logic       led
);

    localparam logic [TMR_W-1:0] FLASH_LAST = TMR_W'(FLASH_MS - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_MS - 1);

    chan_state_t      state;
    logic [3:0]       remaining;
    logic [TMR_W-1:0] tmr;

    // evt_ready is a flop rather than (state == ST_BASE) so that it stays low
    // throughout reset and rises on the first edge after release.
    // NOTE: every register here is written with <= so all of them update
    // together from the same pre-edge values; a blocking '=' would let later
    // lines see already-updated state and change behaviour with line order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_BASE;
            remaining <= '0;
            tmr       <= '0;
            led       <= 1'b0;
            evt_ready <= 1'b0;
        end else begin
            case (state)
                ST_BASE: begin
                    if (evt_valid && evt_ready && (evt_count != 4'd0)) begin
                        state     <= ST_FLASH_ON;
                        remaining <= evt_count;
                        tmr       <= '0;
                        led       <= 1'b1;
                        evt_ready <= 1'b0;
                    end else begin
                        // A zero-count event lands here too: nothing changes.
                        led       <= base_level(mode, slow_phase, fast_phase);
                        evt_ready <= 1'b1;
                    end
                end

                ST_FLASH_ON: begin
                    if (ms_tick) begin
                        if (tmr == FLASH_LAST) begin
                            state <= ST_FLASH_OFF;
                            led   <= 1'b0;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                end

                ST_FLASH_OFF: begin
                    if (ms_tick) begin
                        if (tmr == FLASH_LAST) begin
                            tmr <= '0;
                            if (remaining > 4'd1) begin
                                remaining <= remaining - 4'd1;
                                state     <= ST_FLASH_ON;
                                led       <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                end

                ST_GAP: begin
                    if (ms_tick) begin
                        if (tmr == GAP_LAST) begin
                            state     <= ST_BASE;
                            tmr       <= '0;
                            evt_ready <= 1'b1;
                            led       <= base_level(mode, slow_phase, fast_phase);
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                end

                default: state <= ST_BASE;
            endcase
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// -----------------------------------------------------------------------------
// led_ctrl
//   Two-channel (red / green) status LED controller. Holds the ms prescaler
//   and the shared slow/fast blink phases so both LEDs blink in phase, and
//   one led_channel sequencer per LED. CLK_HZ must be a multiple of 1000.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   mode_r     : red base mode   (00 off, 01 on, 10 slow, 11 fast)
//   mode_g     : green base mode (same encoding)
//   evt_valid  : event request, bit0 red, bit1 green
//   evt_count  : flash count, [3:0] red, [7:4] green
//   evt_ready  : channel in BASE and able to accept, bit0 red, bit1 green
//   r_led      : red LED drive, 1 = lit (flop output)
//   g_led      : green LED drive, 1 = lit (flop output)
// -----------------------------------------------------------------------------
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
    parameter int unsigned FLASH_MS = DEF_FLASH_MS,
    parameter int unsigned GAP_MS   = DEF_GAP_MS,
    parameter int unsigned SLOW_MS  = DEF_SLOW_MS,
    parameter int unsigned FAST_MS  = DEF_FAST_MS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_r,
    input  logic [1:0] mode_g,
    input  logic [1:0] evt_valid,
    input  logic [7:0] evt_count,
    output logic [1:0] evt_ready,
    output logic       r_led,
    output logic       g_led
);

    localparam int unsigned DIV    = CLK_HZ / 1000;
    localparam int unsigned PRE_W  = $clog2(DIV + 1);
    localparam int unsigned SLOW_W = $clog2(SLOW_MS + 1);
    localparam int unsigned FAST_W = $clog2(FAST_MS + 1);
    localparam int unsigned TMR_W  = $clog2(max2(FLASH_MS, GAP_MS) + 1);

    logic [PRE_W-1:0]  pre;
    logic [SLOW_W-1:0] slow_cnt;
    logic [FAST_W-1:0] fast_cnt;
    logic              slow_phase;
    logic              fast_phase;

    logic ms_tick;
    logic slow_toggle;
    logic fast_toggle;
    logic slow_phase_nxt;
    logic fast_phase_nxt;

    // The tick is high during the last prescaler count, so the edge that
    // wraps the prescaler to 0 is the edge on which the tick is acted upon.
    assign ms_tick     = (pre == PRE_W'(DIV - 1));
    assign slow_toggle = ms_tick && (slow_cnt == SLOW_W'(SLOW_MS - 1));
    assign fast_toggle = ms_tick && (fast_cnt == FAST_W'(FAST_MS - 1));

    // Channels register their LED from the post-edge phase so a blinking
    // LED changes on the same edge as the phase flop, not one cycle later.
    assign slow_phase_nxt = slow_phase ^ slow_toggle;
    assign fast_phase_nxt = fast_phase ^ fast_toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            slow_cnt   <= '0;
            fast_cnt   <= '0;
            slow_phase <= 1'b0;
            fast_phase <= 1'b0;
        end else begin
            pre <= ms_tick ? '0 : pre + PRE_W'(1);
            if (ms_tick) begin
                slow_cnt <= slow_toggle ? '0 : slow_cnt + SLOW_W'(1);
                fast_cnt <= fast_toggle ? '0 : fast_cnt + FAST_W'(1);
            end
            slow_phase <= slow_phase_nxt;
            fast_phase <= fast_phase_nxt;
        end
    end

    led_channel #(
        .FLASH_MS (FLASH_MS),
        .GAP_MS   (GAP_MS),
        .TMR_W    (TMR_W)
    ) u_red (
        .clk        (clk),
        .rst_n      (rst_n),
        .ms_tick    (ms_tick),
        .mode       (mode_t'(mode_r)),
        .slow_phase (slow_phase_nxt),
        .fast_phase (fast_phase_nxt),
        .evt_valid  (evt_valid[0]),
        .evt_count  (evt_count[3:0]),
        .evt_ready  (evt_ready[0]),
        .led        (r_led)
    );

    led_channel #(
        .FLASH_MS (FLASH_MS),
        .GAP_MS   (GAP_MS),
        .TMR_W    (TMR_W)
    ) u_green (
        .clk        (clk),
        .rst_n      (rst_n),
        .ms_tick    (ms_tick),
        .mode       (mode_t'(mode_g)),
        .slow_phase (slow_phase_nxt),
        .fast_phase (fast_phase_nxt),
        .evt_valid  (evt_valid[1]),
        .evt_count  (evt_count[7:4]),
        .evt_ready  (evt_ready[1]),
        .led        (g_led)
    );

endmodule

// File: tb/tb_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_ctrl
//   Self-checking bench for led_ctrl at 10 clocks per ms. Every clock edge
//   is compared against a reference model that computes the expected LED
//   and ready levels arithmetically from the edge count since reset release
//   and the millisecond at which each burst was accepted.
// -----------------------------------------------------------------------------
module tb_led_ctrl;

    localparam int CLK_HZ   = 10_000;
    localparam int FLASH_MS = 2;
    localparam int GAP_MS   = 4;
    localparam int SLOW_MS  = 5;
    localparam int FAST_MS  = 2;
    localparam int CPM      = CLK_HZ / 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode_r = 2'b00;
    logic [1:0] mode_g = 2'b00;
    logic [1:0] evt_valid = 2'b00;
    logic [7:0] evt_count = 8'h00;
    logic [1:0] evt_ready;
    logic       r_led;
    logic       g_led;

    led_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .FLASH_MS (FLASH_MS),
        .GAP_MS   (GAP_MS),
        .SLOW_MS  (SLOW_MS),
        .FAST_MS  (FAST_MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_r    (mode_r),
        .mode_g    (mode_g),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .evt_ready (evt_ready),
        .r_led     (r_led),
        .g_led     (g_led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int e        = 0;   // rising edges since the last reset release

    task automatic check(input string name, input logic [7:0] actual,
                         input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)",
                     name, actual, expected, e, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one record per channel describing the last burst.
    // ------------------------------------------------------------------
    typedef struct {
        bit busy;
        int a_ms;    // ms index (edge / CPM) of the accepting edge
        int n;       // flash count
        int end_e;   // first edge back in base behaviour
    } burst_t;

    burst_t bm [2];

    function automatic bit phase(input int half_ms);
        return ((e / (CPM * half_ms)) % 2) == 1;
    endfunction

    function automatic bit base_exp(input logic [1:0] m);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return phase(SLOW_MS);
            default: return phase(FAST_MS);
        endcase
    endfunction

    function automatic bit in_burst(input int ch, input int at);
        return bm[ch].busy && (at < bm[ch].end_e);
    endfunction

    function automatic bit led_exp(input int ch, input logic [1:0] m);
        int k;
        if (in_burst(ch, e)) begin
            k = e / CPM - bm[ch].a_ms;  // ms ticks elapsed since acceptance
            if (k < 2 * FLASH_MS * bm[ch].n)
                return (k % (2 * FLASH_MS)) < FLASH_MS;
            return 1'b0;
        end
        return base_exp(m);
    endfunction

    // Drive one set of inputs for the next rising edge, update the model,
    // then compare all outputs 1 ns after that edge.
    task automatic cycle(input logic [1:0] mr, input logic [1:0] mg,
                         input logic [1:0] v, input logic [7:0] cnt);
        mode_r    = mr;
        mode_g    = mg;
        evt_valid = v;
        evt_count = cnt;
        @(posedge clk);
        e++;
        for (int ch = 0; ch < 2; ch++) begin
            bit rb;
            int n;
            rb = (e >= 2) && !in_burst(ch, e - 1);
            n  = (ch == 1) ? int'(cnt[7:4]) : int'(cnt[3:0]);
            if (rb && v[ch] && n != 0) begin
                bm[ch].busy  = 1'b1;
                bm[ch].a_ms  = e / CPM;
                bm[ch].n     = n;
                bm[ch].end_e = (e / CPM + 2 * FLASH_MS * n + GAP_MS) * CPM;
            end
        end
        #1;
        check("r_led", r_led, led_exp(0, mr));
        check("g_led", g_led, led_exp(1, mg));
        check("evt_ready", evt_ready, {!in_burst(1, e), !in_burst(0, e)});
    endtask

    // Assert reset off-edge, check the reset state, hold, release on a
    // falling edge and check that ready has not risen yet.
    task automatic apply_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check("rst_r_led", r_led, 1'b0);
        check("rst_g_led", g_led, 1'b0);
        check("rst_evt_ready", evt_ready, 2'b00);
        e = 0;
        bm[0].busy = 1'b0;
        bm[1].busy = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", evt_ready, 2'b00);
    endtask

    typedef struct {
        logic [1:0] mr;
        logic [1:0] mg;
        logic       er;
        logic       eg;
    } tvec_t;

    initial begin
        tvec_t tv [8];
        int    r_tog, g_tog, r_bad, g_bad, lo, hi, falls, g_lo;
        bit    pr, pg, done;
        logic [1:0] mr, mg, v;
        logic [7:0] cnt;

        // Base-mode vectors applied in the first ms after release, where
        // both blink phases are still 0.
        tv[0] = '{2'b01, 2'b00, 1'b1, 1'b0};
        tv[1] = '{2'b00, 2'b00, 1'b0, 1'b0};
        tv[2] = '{2'b00, 2'b01, 1'b0, 1'b1};
        tv[3] = '{2'b01, 2'b01, 1'b1, 1'b1};
        tv[4] = '{2'b10, 2'b11, 1'b0, 1'b0};
        tv[5] = '{2'b11, 2'b01, 1'b0, 1'b1};
        tv[6] = '{2'b01, 2'b10, 1'b1, 1'b0};
        tv[7] = '{2'b10, 2'b10, 1'b0, 1'b0};

        apply_reset(3);
        for (int i = 0; i < 8; i++) begin
            cycle(tv[i].mr, tv[i].mg, 2'b00, 8'h00);
            check("tbl_r_led", r_led, tv[i].er);
            check("tbl_g_led", g_led, tv[i].eg);
            if (i == 0) check("first_edge_ready", evt_ready, 2'b11);
        end

        // Slow/fast blink: toggles only on 50/20-cycle boundaries.
        apply_reset(2);
        r_tog = 0; g_tog = 0; r_bad = 0; g_bad = 0; pr = 0; pg = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(2'b10, 2'b11, 2'b00, 8'h00);
            if (r_led != pr) begin r_tog++; if (e % 50 != 0) r_bad++; end
            if (g_led != pg) begin g_tog++; if (e % 20 != 0) g_bad++; end
            pr = r_led;
            pg = g_led;
        end
        check("slow_toggles", 8'(r_tog), 8'd4);
        check("fast_toggles", 8'(g_tog), 8'd10);
        check("slow_misaligned", 8'(r_bad), 8'd0);
        check("fast_misaligned", 8'(g_bad), 8'd0);

        // Red burst of 3, accepted on a tick-aligned edge.
        apply_reset(2);
        while (e < 29) cycle(2'b01, 2'b00, 2'b00, 8'h00);
        lo = 0; hi = 0; falls = 0; pr = 1; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle(2'b01, 2'b00, (i == 0) ? 2'b01 : 2'b00, (i == 0) ? 8'h03 : 8'h00);
            if (evt_ready[0]) done = 1;
            else begin
                lo++;
                if (r_led) hi++;
                if (pr && !r_led) falls++;
                pr = r_led;
            end
        end
        check("burst3_end_seen", done, 1'b1);
        check("burst3_ready_low", 8'(lo), 8'd160);
        check("burst3_lit_cycles", 8'(hi), 8'd60);
        check("burst3_pulses", 8'(falls), 8'd3);
        check("burst3_back_to_mode", r_led, 1'b1);

        // Simultaneous events: green count 0, red count 1, and a second red
        // request mid-burst that must be dropped.
        apply_reset(2);
        while (e < 29) cycle(2'b00, 2'b01, 2'b00, 8'h00);
        lo = 0; hi = 0; g_lo = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (i == 0)      begin v = 2'b11; cnt = 8'h01; end
            else if (i == 5) begin v = 2'b01; cnt = 8'h03; end
            else             begin v = 2'b00; cnt = 8'h00; end
            cycle(2'b00, 2'b01, v, cnt);
            if (!evt_ready[1] || !g_led) g_lo++;
            if (evt_ready[0]) done = 1;
            else begin
                lo++;
                if (r_led) hi++;
            end
        end
        check("dual_end_seen", done, 1'b1);
        check("dual_red_ready_low", 8'(lo), 8'd80);
        check("dual_red_lit", 8'(hi), 8'd20);
        check("dual_green_disturbed", 8'(g_lo), 8'd0);
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(2'b00, 2'b01, 2'b00, 8'h00);
            if (r_led || !evt_ready[0]) hi++;
        end
        check("dropped_evt_not_queued", 8'(hi), 8'd0);

        // Reset in the middle of FLASH_ON aborts the burst for good.
        apply_reset(2);
        while (e < 29) cycle(2'b00, 2'b00, 2'b00, 8'h00);
        cycle(2'b00, 2'b00, 2'b01, 8'h05);
        repeat (5) cycle(2'b00, 2'b00, 2'b00, 8'h00);
        check("flash_on_before_reset", r_led, 1'b1);
        apply_reset(3);
        cycle(2'b00, 2'b00, 2'b00, 8'h00);
        check("post_reset_ready", evt_ready[0], 1'b1);
        hi = 0;
        for (int i = 0; i < 150; i++) begin
            cycle(2'b00, 2'b00, 2'b00, 8'h00);
            if (r_led || !evt_ready[0]) hi++;
        end
        check("burst_not_resumed", 8'(hi), 8'd0);

        // Randomised traffic against the model, with occasional resets.
        apply_reset(2);
        mr = 2'b00;
        mg = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) mr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) mg = 2'($urandom_range(0, 3));
            v[0] = ($urandom_range(0, 24) == 0);
            v[1] = ($urandom_range(0, 24) == 0);
            cnt  = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))};
            cycle(mr, mg, v, cnt);
            if ($urandom_range(0, 1499) == 0) apply_reset(int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
